// File: rtl/sig_fetch_responder.sv
// Serves a window of BRAM words one per request edge into a held output register.
// Optional RESP_STATS_EN macro adds overrunCount and wordsServed outputs.
module sig_fetch_responder #(
    parameter int unsigned BRAM_DEPTH = 4096,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 2,
    localparam int unsigned AW        = $clog2(BRAM_DEPTH)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [AW-1:0]     srcBase,
    input  logic [AW:0]       srcLen,
    input  logic              load,
    input  logic              request,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              bramEn,
    output logic [AW-1:0]     bramAddr,
    input  logic [DATA_W-1:0] bramDout
`ifdef RESP_STATS_EN
    ,
    output logic [7:0]        overrunCount,
    output logic [AW:0]       wordsServed
`endif
);

    typedef enum logic [2:0] {
        s_idle,
        s_prefetch,
        s_wait,
        s_ready,
        s_done
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t        state;
    state_t        state_next;
    logic          req_prev;
    logic          req_edge;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_next;
    logic [AW:0]   served;
    logic [AW:0]   served_next;
    logic [AW:0]   len;
    logic [1:0]    wait_cnt;

    assign req_edge    = request & ~req_prev;
    assign served_next = served + (AW+1)'(1);
    // Explicit wrap keeps non-power-of-two depths correct.
    assign addr_next   = (addr == AW'(BRAM_DEPTH - 1)) ? '0 : addr + AW'(1);
    assign bramAddr    = addr;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= s_idle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bramEn     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            s_prefetch: begin
                bramEn     = 1'b1;
                busy       = 1'b1;
                state_next = s_wait;
            end
            s_wait: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_next = s_ready;
                end
            end
            s_ready: begin
                if (req_edge) begin
                    state_next = (served_next == len) ? s_done : s_prefetch;
                end
            end
            s_done: begin
                done = 1'b1;
            end
            default: ;
        endcase
        // Load outranks every state, including an in-flight read.
        if (load) begin
            state_next = (srcLen == '0) ? s_done : s_prefetch;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            req_prev  <= 1'b0;
            addr      <= '0;
            served    <= '0;
            len       <= '0;
            wait_cnt  <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            req_prev <= request;
            if (load) begin
                addr      <= srcBase;
                served    <= '0;
                len       <= srcLen;
                wait_cnt  <= '0;
                dataValid <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    s_prefetch: begin
                        wait_cnt <= '0;
                        if (req_edge) begin
                            overrun <= 1'b1;
                        end
                    end
                    s_wait: begin
                        wait_cnt <= wait_cnt + 2'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            dataOut   <= bramDout;
                            dataValid <= 1'b1;
                        end
                        if (req_edge) begin
                            overrun <= 1'b1;
                        end
                    end
                    s_ready: begin
                        if (req_edge) begin
                            served    <= served_next;
                            dataValid <= 1'b0;
                            if (served_next != len) begin
                                addr <= addr_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RESP_STATS_EN
    logic [7:0] overrun_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overrun_cnt <= '0;
        end else if (load) begin
            overrun_cnt <= '0;
        end else if (req_edge && busy && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    assign overrunCount = overrun_cnt;
    assign wordsServed  = served;
`endif

endmodule

// File: tb/tb_sig_fetch_responder.sv
// Scoreboard bench for sig_fetch_responder: a window-level model predicts each word and its arrival cycle.
module tb_sig_fetch_responder;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned DW    = 32;
    localparam int unsigned RL    = 2;
    localparam int unsigned AW    = 12;

    logic          clk = 1'b0;
    logic          resetN;
    logic [AW-1:0] srcBase;
    logic [AW:0]   srcLen;
    logic          load;
    logic          request;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          busy;
    logic          done;
    logic          overrun;
    logic          bramEn;
    logic [AW-1:0] bramAddr;
    logic [DW-1:0] bramDout;
`ifdef RESP_STATS_EN
    logic [7:0]    overrunCount;
    logic [AW:0]   wordsServed;
`endif

    sig_fetch_responder #(
        .BRAM_DEPTH(DEPTH),
        .DATA_W    (DW),
        .RD_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .srcBase  (srcBase),
        .srcLen   (srcLen),
        .load     (load),
        .request  (request),
        .dataOut  (dataOut),
        .dataValid(dataValid),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .bramEn   (bramEn),
        .bramAddr (bramAddr),
        .bramDout (bramDout)
`ifdef RESP_STATS_EN
        ,
        .overrunCount(overrunCount),
        .wordsServed (wordsServed)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM: data for a read shows up RL cycles after bramEn; otherwise junk.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] pd [RL];
    bit            pv [RL];
    logic [DW-1:0] junk;
    always @(posedge clk) begin
        pd[0] <= mem[bramAddr];
        pv[0] <= bramEn;
        for (int i = 1; i < RL; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
        end
        junk <= $urandom;
    end
    assign bramDout = pv[RL-1] ? pd[RL-1] : junk;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Window-level reference model.
    bit m_loaded  = 0;
    bit m_done    = 0;
    bit m_overrun = 0;
    int m_idx     = 0;
    int m_len     = 0;
    int m_base    = 0;
    int m_ready   = 0;
    int m_ovc     = 0;

    function automatic void push_word(input int c);
        exp_t e;
        m_ready = c + 2 + RL;
        e.data  = mem[(m_base + m_idx) % DEPTH];
        e.at    = m_ready;
        exp_q.push_back(e);
    endfunction

    function automatic void model_load(input int c, input int base, input int len);
        exp_q.delete();
        m_loaded  = 1;
        m_overrun = 0;
        m_ovc     = 0;
        m_idx     = 0;
        m_len     = len;
        m_base    = base;
        m_done    = (len == 0);
        if (len != 0) push_word(c);
    endfunction

    function automatic void model_req(input int c);
        if (!m_loaded || m_done) return;
        if (c < m_ready) begin
            m_overrun = 1;
            if (m_ovc < 255) m_ovc++;
            return;
        end
        m_idx++;
        if (m_idx == m_len) m_done = 1;
        else push_word(c);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: each dataValid rise must match the next predicted word and cycle.
    bit prev_valid = 0;
    always @(negedge clk) begin
        exp_t e;
        if (resetN !== 1'b1) begin
            prev_valid = 0;
        end else begin
            if (dataValid && !prev_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word (cycle %0d)", dataOut, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (dataOut !== e.data || cyc != e.at) begin
                        failures++;
                        $display("FAIL word: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                                 dataOut, cyc, e.data, e.at);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                failures++;
                e = exp_q.pop_front();
                $display("FAIL missing_word: got nothing expected 0x%0h at cycle %0d", e.data, e.at);
            end
            prev_valid = dataValid;
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input int base, input int len);
        srcBase = AW'(base);
        srcLen  = (AW+1)'(len);
        load    = 1'b1;
        model_load(cyc, base, len);
        next_cycle();
        load = 1'b0;
    endtask

    task automatic do_req();
        request = 1'b1;
        model_req(cyc);
        next_cycle();
        request = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 16 && cyc < m_ready; i++) next_cycle();
    endtask

    task automatic settle_check(input string tag);
        repeat (RL + 4) next_cycle();
        check({tag, "_done"}, done, m_done);
        check({tag, "_overrun"}, overrun, m_overrun);
`ifdef RESP_STATS_EN
        check({tag, "_ovcount"}, overrunCount, m_ovc);
        check({tag, "_served"}, wordsServed, m_idx);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        int base;
        int len;
        int nreq;
        resetN  = 1'b0;
        load    = 1'b0;
        request = 1'b0;
        srcBase = '0;
        srcLen  = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[10]  = 32'hA0A0_0001;
        mem[11]  = 32'hB0B0_0002;
        mem[12]  = 32'hC0C0_0003;
        mem[100] = 32'h1234_5678;

        repeat (2) @(negedge clk);
        check("reset_dataOut", dataOut, 0);
        check("reset_dataValid", dataValid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_overrun", overrun, 0);
        check("reset_bramEn", bramEn, 0);
        check("reset_bramAddr", bramAddr, 0);
        #1 resetN = 1'b1;
        next_cycle();

        // Basic window of three words.
        do_load(10, 3);
        check("basic_bramEn", bramEn, 1);
        check("basic_bramAddr", bramAddr, 10);
        wait_ready();
        check("basic_valid", dataValid, 1);
        check("basic_first", dataOut, 32'hA0A0_0001);
        repeat (3) begin
            do_req();
            repeat (7) next_cycle();
        end
        check("basic_done", done, 1);
        check("basic_overrun", overrun, 0);
        check("basic_last", dataOut, 32'hC0C0_0003);

        // Window straddling the top of the BRAM.
        do_load(4095, 2);
        check("wrap_addr0", bramAddr, 4095);
        wait_ready();
        do_req();
        check("wrap_bramEn", bramEn, 1);
        check("wrap_addr1", bramAddr, 0);
        repeat (6) next_cycle();
        check("wrap_not_done", done, 0);
        do_req();
        settle_check("wrap");

        // Request edge while a read is in flight.
        do_load(200, 4);
        wait_ready();
        do_req();
        next_cycle();
        check("ovr_busy", busy, 1);
        do_req();
        wait_ready();
        check("ovr_addr", bramAddr, 201);
        settle_check("ovr");

        // Zero-length window.
        do_load(5, 0);
        check("zero_done", done, 1);
        quiet = 1;
        repeat (6) begin
            if (bramEn || dataValid) quiet = 0;
            next_cycle();
        end
        check("zero_quiet", quiet, 1);

        // Reload while the first read is still in flight.
        do_load(10, 5);
        next_cycle();
        do_load(100, 2);
        wait_ready();
        check("abort_word", dataOut, 32'h1234_5678);
        settle_check("abort");

        // Randomised windows, request spacing and aborts.
        for (int w = 0; w < 10; w++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 6);
            do_load(base, len);
            nreq = $urandom_range(0, len + 1);
            for (int r = 0; r < nreq; r++) begin
                repeat ($urandom_range(1, 6)) next_cycle();
                do_req();
            end
            if ($urandom_range(0, 3) != 0) settle_check("rand");
        end
        settle_check("rand_final");

        // Asynchronous reset during a read.
        do_load(300, 3);
        next_cycle();
        #2 resetN = 1'b0;
        #1;
        check("areset_dataOut", dataOut, 0);
        check("areset_dataValid", dataValid, 0);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_bramEn", bramEn, 0);
        check("areset_bramAddr", bramAddr, 0);
        exp_q.delete();
        m_loaded  = 0;
        m_done    = 0;
        m_overrun = 0;
        m_idx     = 0;
        m_ovc     = 0;
        next_cycle();
        next_cycle();
        resetN = 1'b1;
        do_req();
        quiet = 1;
        repeat (8) begin
            if (dataValid || busy || done || bramEn) quiet = 0;
            next_cycle();
        end
        check("post_reset_idle", quiet, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
